ins_fetcher: RTL and testbench
==============================

// Module: ins_fetcher
// PURPOSE
//  Instruction-fetch stage directly upstream of the Decoder. Holds the PC,
//  looks it up in a direct-mapped one-word-per-line I-cache, fetches misses
//  from the memory controller, and presents one instruction at a time to the
//  Decoder. Follows Decoder next_PC/is_stall and redirects on ROB clear.
// PARAMETERS
//  ICACHE_IDX_BIT  6   log2 of I-cache lines (64 lines, 1 word each)
//  RESET_PC        0   PC loaded on reset
// PORTS
//  clk_in        in   1   single clock, all state updates on rising edge
//  rst_in        in   1   reset, synchronous, active-high
//  rdy_in        in   1   global ready; low = freeze all state
//  inst_input    out  1   inst/inst_addr valid to Decoder
//  inst          out  32  instruction word
//  inst_addr     out  32  address of inst
//  dec_stall     in   1   Decoder is_stall; low while inst_input=1 = consumed
//  dec_next_pc   in   32  Decoder next_PC, sampled only on consume
//  rob_clear     in   1   ROB flush/mispredict redirect
//  rob_clear_pc  in   32  redirect target, sampled when rob_clear=1
//  mem_req       out  1   word fetch request to memory controller
//  mem_addr      out  32  word-aligned fetch address
//  mem_ack       in   1   1-cycle pulse: mem_data valid, request done
//  mem_data      in   32  fetched word
// BEHAVIOUR
//  - Reset (rst_in=1 at edge): pc=RESET_PC, inst_input=0, inst=0,
//    inst_addr=0, mem_req=0, mem_addr=0, drop=0, state=IDLE, all valid bits 0.
//  - rdy_in=0 and rst_in=0: every register holds; mem_ack ignored (controller
//    must not ack while rdy_in=0).
//  - Cache: index=pc[ICACHE_IDX_BIT+1:2], tag=pc[31:ICACHE_IDX_BIT+2];
//    hit = valid[index] && tag match. pc[1:0] is always 0.
//  - Priority per cycle: rst_in > !rdy_in > rob_clear > consume > lookup.
//  - States: IDLE (lookup/present), WAIT (miss outstanding).
//  - IDLE, inst_input=0, hit: next cycle inst_input=1, inst=line data,
//    inst_addr=pc. Hit latency 1 cycle; throughput 1 inst per 2 cycles.
//  - IDLE, inst_input=0, miss: mem_req=1, mem_addr=pc, go WAIT.
//  - inst_input=1 && dec_stall=1: inst, inst_addr, inst_input, pc all held.
//  - inst_input=1 && dec_stall=0 (consume): pc=dec_next_pc, inst_input=0.
//  - WAIT: mem_req/mem_addr held stable until mem_ack. On mem_ack: write
//    mem_data into line of mem_addr, set its valid, mem_req=0, go IDLE;
//    if drop=0 also inst_input=1, inst=mem_data, inst_addr=mem_addr;
//    if drop=1 present nothing and clear drop.
//  - rob_clear=1 (rdy_in=1): pc=rob_clear_pc, inst_input=0, consume ignored.
//    In IDLE: stay IDLE. In WAIT (incl. same cycle as mem_ack): outstanding
//    request is never aborted; drop=1 (fill still performed, word discarded);
//    if the ack arrives in the same cycle, fill, go IDLE, drop stays 0.
//  - Cache is never invalidated except by reset (no self-modifying code).
//  - PC arithmetic is 32-bit, wraps modulo 2^32 without special handling.
// TESTING
//  1. Reset, RESET_PC=0, mem acks 3 cycles after req with 0x00500093 ->
//     mem_addr=0, then inst_input=1, inst=0x00500093, inst_addr=0.
//  2. Consume with dec_next_pc=0 after line 0 filled -> no mem_req; inst
//     valid again 1 cycle later, inst_addr=0 (hit path).
//  3. dec_stall=1 for 5 cycles while inst_input=1 -> inst/inst_addr
//     unchanged, no mem_req; stall low -> pc=dec_next_pc=0x4, inst_input=0.
//  4. rob_clear with rob_clear_pc=0x100 during WAIT on 0x8 -> on ack line 2
//     filled, inst_input stays 0; next mem_addr=0x100; later fetch of 0x8 hits.
//  5. rob_clear and consume same cycle (next_pc=0x10, clear_pc=0x200) ->
//     pc=0x200; rob_clear coincident with mem_ack -> fill, nothing presented.
//  6. rdy_in=0 for 4 cycles mid-WAIT and while inst_input=1 -> all outputs
//     frozen; resumes identically when rdy_in returns high.

Source files
------------

// File: rtl/ins_fetcher.sv
// Instruction-fetch stage: PC register, direct-mapped one-word-per-line I-cache,
// miss handling toward the memory controller, and a one-entry hand-off to the Decoder.
module ins_fetcher #(
  parameter int          ICACHE_IDX_BIT = 6,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        inst_input,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  input  logic        dec_stall,
  input  logic [31:0] dec_next_pc,
  input  logic        rob_clear,
  input  logic [31:0] rob_clear_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
);

  localparam int LINES = 1 << ICACHE_IDX_BIT;
  localparam int TAG_W = 30 - ICACHE_IDX_BIT;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                    r_state;
  logic [31:0]               r_pc;
  logic                      r_inst_input;
  logic [31:0]               r_inst;
  logic [31:0]               r_inst_addr;
  logic                      r_mem_req;
  logic [31:0]               r_mem_addr;
  logic                      r_drop;

  logic [31:0]               r_line_data [LINES];
  logic [TAG_W-1:0]          r_line_tag  [LINES];
  logic [LINES-1:0]          r_line_valid;

  state_t                    w_state_nx;
  logic [31:0]               w_pc_nx;
  logic                      w_inst_input_nx;
  logic [31:0]               w_inst_nx;
  logic [31:0]               w_inst_addr_nx;
  logic                      w_mem_req_nx;
  logic [31:0]               w_mem_addr_nx;
  logic                      w_drop_nx;
  logic                      w_fill;

  logic [ICACHE_IDX_BIT-1:0] w_idx;
  logic [TAG_W-1:0]          w_tag;
  logic [ICACHE_IDX_BIT-1:0] w_fill_idx;
  logic [TAG_W-1:0]          w_fill_tag;
  logic                      w_hit;

  assign w_idx      = r_pc[ICACHE_IDX_BIT+1:2];
  assign w_tag      = r_pc[31:ICACHE_IDX_BIT+2];
  assign w_fill_idx = r_mem_addr[ICACHE_IDX_BIT+1:2];
  assign w_fill_tag = r_mem_addr[31:ICACHE_IDX_BIT+2];
  assign w_hit      = r_line_valid[w_idx] && (r_line_tag[w_idx] == w_tag);

  always_comb begin
    // NOTE: every output of this block gets a hold value first, so no path leaves one unassigned and no latch is inferred.
    w_state_nx      = r_state;
    w_pc_nx         = r_pc;
    w_inst_input_nx = r_inst_input;
    w_inst_nx       = r_inst;
    w_inst_addr_nx  = r_inst_addr;
    w_mem_req_nx    = r_mem_req;
    w_mem_addr_nx   = r_mem_addr;
    w_drop_nx       = r_drop;
    w_fill          = 1'b0;

    if (rdy_in) begin
      // An outstanding miss always completes its fill, even across a redirect.
      if (r_state == S_WAIT) begin
        if (mem_ack) begin
          w_fill       = 1'b1;
          w_mem_req_nx = 1'b0;
          w_state_nx   = S_IDLE;
          w_drop_nx    = 1'b0;
          if (!r_drop && !rob_clear) begin
            w_inst_input_nx = 1'b1;
            w_inst_nx       = mem_data;
            w_inst_addr_nx  = r_mem_addr;
          end
        end else if (rob_clear) begin
          w_drop_nx = 1'b1;
        end
      end

      if (rob_clear) begin
        w_pc_nx         = rob_clear_pc;
        w_inst_input_nx = 1'b0;
      end else if (r_inst_input) begin
        if (!dec_stall) begin
          w_pc_nx         = dec_next_pc;
          w_inst_input_nx = 1'b0;
        end
      end else if (r_state == S_IDLE) begin
        if (w_hit) begin
          w_inst_input_nx = 1'b1;
          w_inst_nx       = r_line_data[w_idx];
          w_inst_addr_nx  = r_pc;
        end else begin
          w_mem_req_nx  = 1'b1;
          w_mem_addr_nx = r_pc;
          w_state_nx    = S_WAIT;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_in) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_inst_input <= 1'b0;
      r_inst       <= 32'h0;
      r_inst_addr  <= 32'h0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_drop       <= 1'b0;
      r_line_valid <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_pc         <= w_pc_nx;
      r_inst_input <= w_inst_input_nx;
      r_inst       <= w_inst_nx;
      r_inst_addr  <= w_inst_addr_nx;
      r_mem_req    <= w_mem_req_nx;
      r_mem_addr   <= w_mem_addr_nx;
      r_drop       <= w_drop_nx;
      if (w_fill) r_line_valid[w_fill_idx] <= 1'b1;
    end
  end

  // NOTE: line data and tags are not reset; the valid bits alone make stale contents unreachable.
  always_ff @(posedge clk_in) begin
    if (w_fill) begin
      r_line_data[w_fill_idx] <= mem_data;
      r_line_tag[w_fill_idx]  <= w_fill_tag;
    end
  end

  assign inst_input = r_inst_input;
  assign inst       = r_inst;
  assign inst_addr  = r_inst_addr;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;

endmodule

// File: tb/tb_ins_fetcher.sv
// Directed self-checking bench for ins_fetcher: miss/hit paths, stall, consume,
// redirect during a miss and on the ack cycle, freeze via rdy_in, tag aliasing.
module tb_ins_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        inst_input;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        dec_stall;
  logic [31:0] dec_next_pc;
  logic        rob_clear;
  logic [31:0] rob_clear_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;

  int checks   = 0;
  int failures = 0;

  ins_fetcher #(.ICACHE_IDX_BIT(6), .RESET_PC(32'h0)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .inst_input   (inst_input),
    .inst         (inst),
    .inst_addr    (inst_addr),
    .dec_stall    (dec_stall),
    .dec_next_pc  (dec_next_pc),
    .rob_clear    (rob_clear),
    .rob_clear_pc (rob_clear_pc),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_present(input string tag, input logic [31:0] exp_addr, input logic [31:0] exp_inst);
    check({tag, ".valid"}, {31'b0, inst_input}, 32'd1);
    check({tag, ".addr"},  inst_addr, exp_addr);
    check({tag, ".inst"},  inst, exp_inst);
  endtask

  task automatic check_req(input string tag, input logic [31:0] exp_addr);
    check({tag, ".req"},  {31'b0, mem_req}, 32'd1);
    check({tag, ".maddr"}, mem_addr, exp_addr);
  endtask

  // Pulse mem_ack for exactly one cycle with the given word.
  task automatic ack(input logic [31:0] data);
    mem_ack  = 1'b1;
    mem_data = data;
    tick();
    mem_ack  = 1'b0;
    mem_data = 32'h0;
  endtask

  // One-cycle consume of the presented instruction.
  task automatic consume(input logic [31:0] next_pc);
    dec_stall   = 1'b0;
    dec_next_pc = next_pc;
    tick();
    dec_stall   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; dec_stall = 1'b1; dec_next_pc = 32'h0;
    rob_clear = 1'b0; rob_clear_pc = 32'h0; mem_ack = 1'b0; mem_data = 32'h0;
    tick(); tick();
    rst_in = 1'b0;

    // 1. reset state, then cold miss on RESET_PC, ack 3 cycles after the request
    check("rst.valid", {31'b0, inst_input}, 32'd0);
    check("rst.inst",  inst, 32'h0);
    check("rst.addr",  inst_addr, 32'h0);
    check("rst.req",   {31'b0, mem_req}, 32'd0);
    check("rst.maddr", mem_addr, 32'h0);
    tick();
    check_req("t1.miss", 32'h0);
    tick(); tick();
    check_req("t1.hold", 32'h0);
    ack(32'h0050_0093);
    check_present("t1.fill", 32'h0, 32'h0050_0093);
    check("t1.req_low", {31'b0, mem_req}, 32'd0);

    // 2. consume back to 0: hit path, valid again one cycle later
    consume(32'h0);
    check("t2.taken", {31'b0, inst_input}, 32'd0);
    check("t2.noreq", {31'b0, mem_req}, 32'd0);
    tick();
    check_present("t2.hit", 32'h0, 32'h0050_0093);
    check("t2.noreq2", {31'b0, mem_req}, 32'd0);

    // 3. five stalled cycles hold everything, then consume to 0x4
    dec_next_pc = 32'h4;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_present($sformatf("t3.stall%0d", i), 32'h0, 32'h0050_0093);
      check($sformatf("t3.noreq%0d", i), {31'b0, mem_req}, 32'd0);
    end
    consume(32'h4);
    check("t3.taken", {31'b0, inst_input}, 32'd0);
    tick();
    check_req("t3.miss4", 32'h4);
    tick();
    ack(32'h0000_0013);
    check_present("t3.fill4", 32'h4, 32'h0000_0013);

    // 4. redirect to 0x100 while the miss on 0x8 is outstanding
    consume(32'h8);
    tick();
    check_req("t4.miss8", 32'h8);
    rob_clear = 1'b1; rob_clear_pc = 32'h100;
    tick();
    rob_clear = 1'b0;
    check_req("t4.kept", 32'h8);
    check("t4.noinst", {31'b0, inst_input}, 32'd0);
    tick();
    check_req("t4.kept2", 32'h8);
    ack(32'hDEAD_0008);
    check("t4.dropped", {31'b0, inst_input}, 32'd0);
    check("t4.req_low", {31'b0, mem_req}, 32'd0);
    tick();
    check_req("t4.miss100", 32'h100);
    ack(32'h0100_0100);
    check_present("t4.fill100", 32'h100, 32'h0100_0100);
    consume(32'h8);
    tick();
    check_present("t4.hit8", 32'h8, 32'hDEAD_0008);
    check("t4.noreq8", {31'b0, mem_req}, 32'd0);

    // 5a. redirect wins over a same-cycle consume
    dec_stall = 1'b0; dec_next_pc = 32'h10;
    rob_clear = 1'b1; rob_clear_pc = 32'h200;
    tick();
    dec_stall = 1'b1; rob_clear = 1'b0;
    check("t5.cleared", {31'b0, inst_input}, 32'd0);
    tick();
    check_req("t5.miss200", 32'h200);
    // 5b. redirect on the ack cycle: fill, present nothing, no stale drop left
    rob_clear = 1'b1; rob_clear_pc = 32'h20;
    ack(32'h0200_AAAA);
    rob_clear = 1'b0;
    check("t5.nopresent", {31'b0, inst_input}, 32'd0);
    check("t5.req_low", {31'b0, mem_req}, 32'd0);
    tick();
    check_req("t5.miss20", 32'h20);
    ack(32'h0020_0020);
    check_present("t5.fill20", 32'h20, 32'h0020_0020);
    consume(32'h200);
    tick();
    check_present("t5.hit200", 32'h200, 32'h0200_AAAA);

    // 6a. freeze while presenting: consume and redirect requests are ignored
    rdy_in = 1'b0; dec_stall = 1'b0; dec_next_pc = 32'h30;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_present($sformatf("t6.frz_pres%0d", i), 32'h200, 32'h0200_AAAA);
    end
    rdy_in = 1'b1;
    tick();
    dec_stall = 1'b1;
    check("t6.resume_take", {31'b0, inst_input}, 32'd0);
    tick();
    check_req("t6.miss30", 32'h30);
    // 6b. freeze mid-WAIT, including an ignored redirect
    rdy_in = 1'b0; rob_clear = 1'b1; rob_clear_pc = 32'h40;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_req($sformatf("t6.frz_wait%0d", i), 32'h30);
      check($sformatf("t6.frz_noinst%0d", i), {31'b0, inst_input}, 32'd0);
    end
    rdy_in = 1'b1; rob_clear = 1'b0;
    ack(32'h0030_0030);
    check_present("t6.fill30", 32'h30, 32'h0030_0030);

    // Line 0 now holds 0x200: fetching 0x0 must miss on the tag compare
    consume(32'h0);
    tick();
    check_req("alias.miss0", 32'h0);
    check("alias.noinst", {31'b0, inst_input}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
